// File: rtl/if_fetch.sv
// Instruction fetch stage: PC register, redirect/branch capture, SRAM request.
// Ports: clk, rst, flush/new_pc, stall, br_bus in; inst_sram_* and if_to_id_bus out.
module if_fetch #(
  parameter logic [31:0] RESET_PC    = 32'hBFC0_0000,
  parameter int          IF_TO_ID_WD = 66,
  parameter int          STALL_WD    = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [31:0]            new_pc,
  input  logic [STALL_WD-1:0]    stall,
  input  logic [32:0]            br_bus,
  output logic                   inst_sram_en,
  output logic [7:0]             inst_sram_wen,
  output logic [31:0]            inst_sram_addr,
  output logic [63:0]            inst_sram_wdata,
  output logic [IF_TO_ID_WD-1:0] if_to_id_bus
);

  localparam logic [31:0] PC_INIT = RESET_PC - 32'd8;

  logic [31:0] pc_q,   pc_d;
  logic        ce_q,   ce_d;
  logic        pend_q, pend_d;
  logic [31:0] rpc_q,  rpc_d;
  logic        disc_q, disc_d;

  logic        hold_w;
  logic        br_tkn_w;
  logic [31:0] br_tgt_w;
  logic [31:0] pc_al_w;
  logic [31:0] pc_seq_w;
  logic [65:0] bus_w;

  assign hold_w   = stall[0];
  assign br_tkn_w = br_bus[32];
  assign br_tgt_w = br_bus[31:0];
  assign pc_al_w  = {pc_q[31:3], 3'b000};
  assign pc_seq_w = pc_al_w + 32'd8;

  always_comb begin
    pc_d   = pc_q;
    ce_d   = ce_q;
    pend_d = pend_q;
    rpc_d  = rpc_q;
    disc_d = disc_q;
    if (flush) begin
      pc_d   = new_pc;
      ce_d   = 1'b1;
      pend_d = 1'b0;
      disc_d = 1'b0;
    end else if (hold_w) begin
      // Keep a branch resolved during a stall so it is taken later.
      if (br_tkn_w) begin
        pend_d = 1'b1;
        rpc_d  = br_tgt_w;
      end
    end else begin
      ce_d = 1'b1;
      if (pend_q) begin
        pc_d   = rpc_q;
        pend_d = 1'b0;
        disc_d = 1'b1;
      end else if (br_tkn_w) begin
        pc_d   = br_tgt_w;
        disc_d = 1'b1;
      end else begin
        pc_d   = pc_seq_w;
        disc_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= PC_INIT;
      ce_q   <= 1'b0;
      pend_q <= 1'b0;
      rpc_q  <= 32'h0;
      disc_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      ce_q   <= ce_d;
      pend_q <= pend_d;
      rpc_q  <= rpc_d;
      disc_q <= disc_d;
    end
  end

  assign inst_sram_en    = ce_q & ~hold_w;
  assign inst_sram_wen   = 8'h00;
  assign inst_sram_addr  = pc_al_w;
  assign inst_sram_wdata = 64'h0;

  assign bus_w        = {disc_q, ce_q, pc_q, pc_al_w};
  assign if_to_id_bus = IF_TO_ID_WD'(bus_w);

  logic unused_stall_w;
  if (STALL_WD > 1) begin : g_unused
    assign unused_stall_w = ^stall[STALL_WD-1:1];
  end else begin : g_nounused
    assign unused_stall_w = 1'b0;
  end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'hBFC0_0000, first fetch address after reset.
REQ-002 Parameter IF_TO_ID_WD, default 66, width of if_to_id_bus.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  exception/eret redirect request.
REQ-006 new_pc  input  32  redirect target; valid while flush=1.
REQ-007 stall  input  `StallBus  pipeline stall vector; stall[0]=1 holds the PC.
REQ-008 br_bus  input  33  branch resolution from ID: [32] taken, [31:0] target.
REQ-009 inst_sram_en  output  1  instruction fetch enable.
REQ-010 inst_sram_wen  output  8  byte write enables; constant 8'h00.
REQ-011 inst_sram_addr  output  32  8-byte-aligned fetch address; the 64-bit read data returns one cycle later.
REQ-012 inst_sram_wdata  output  64  constant 64'h0.
REQ-013 if_to_id_bus  output  IF_TO_ID_WD  {discard_current_inst[65], ce[64], pc_idef[63:32], id_pc[31:0]}.

Function
REQ-014 Registers: pc_r[31:0], ce_r, redirect_pend, redirect_pc[31:0], discard_r.
REQ-015 pc_idef SHALL equal pc_r; id_pc SHALL equal {pc_r[31:3],3'b000}.
REQ-016 ce SHALL equal ce_r; inst_sram_en SHALL equal ce_r & ~stall[0].
REQ-017 inst_sram_addr SHALL equal {pc_r[31:3],3'b000}, combinational from pc_r.
REQ-018 Sequential next PC: {pc_r[31:3],3'b000}+8, wrapping modulo 2^32. When pc_r[2]=1, only the upper word of the pair is consumed.
REQ-019 Next-PC priority, highest first: flush -> new_pc; redirect_pend -> redirect_pc; br_bus[32] -> br_bus[31:0]; otherwise sequential.
REQ-020 flush SHALL update pc_r even when stall[0]=1, and SHALL clear redirect_pend and discard_r.
REQ-021 When stall[0]=1 and flush=0, pc_r and ce_r SHALL hold.
REQ-022 When br_bus[32]=1 and stall[0]=1, the block SHALL set redirect_pend=1 and redirect_pc=br_bus[31:0], so that no taken branch is lost.
REQ-023 A second taken branch while redirect_pend=1 SHALL overwrite redirect_pc.
REQ-024 redirect_pend SHALL clear on the first unstalled cycle, in which pc_r loads redirect_pc.
REQ-025 discard_current_inst SHALL equal discard_r.
- discard_r is set to 1 on the edge where pc_r loads a branch or pending-redirect target.
- Otherwise discard_r is 0 on every unstalled edge, and it holds during a stall.
- This marks the first bundle after a redirect, so that ID realigns on the target PC.
REQ-026 Misaligned targets (target[1:0]!=0) SHALL be loaded unchanged; exception detection happens downstream.
REQ-027 Latency: new pc_r is visible on if_to_id_bus 1 cycle after the redirect edge; the matching SRAM data arrives 1 cycle after that.

Reset
REQ-028 On rst=1 the block SHALL set pc_r=RESET_PC-8, ce_r=0, redirect_pend=0, redirect_pc=0 and discard_r=0.
REQ-029 While rst=1, outputs SHALL be: if_to_id_bus=66'h0 except pc fields = RESET_PC-8; inst_sram_en=0.
REQ-030 On the first edge with rst=0 and stall[0]=0, the block SHALL set ce_r=1 and pc_r=RESET_PC.
REQ-031 Reset asserted mid-stall or with redirect_pend=1 SHALL discard all pending state.

Verification
REQ-032 Reset release, no stall, 4 cycles -> pc_idef = BFC00000, BFC00008, BFC00010, BFC00018; inst_sram_en=1; discard=0.
REQ-033 pc_r=BFC00010 and br_bus={1,BFC00104} -> next pc_idef=BFC00104, id_pc=BFC00100, discard=1; the following cycle gives pc_idef=BFC00108, discard=0.
REQ-034 stall[0]=1 for 3 cycles at pc_r=BFC00020 with br_bus={1,BFC00200} in stall cycle 1 -> PC holds at BFC00020 and inst_sram_en=0; the first unstalled edge gives pc_idef=BFC00200, discard=1.
REQ-035 flush=1, new_pc=BFC00380, with simultaneous br_bus[32]=1 and stall[0]=1 -> next pc_idef=BFC00380, redirect_pend=0, discard=0.
REQ-036 pc_r=FFFFFFF8, no events -> next pc_idef=00000000, ce stays 1.
